data_sram_responder: RTL and testbench

//  Slave end of the pipeline data-RAM port driven by the EX stage (en/addr/wdata/we).

---
 rtl/data_sram_responder.sv | 91 +++++++++
 tb/tb_data_sram_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// Word-organised data RAM slave for the EX-stage port: byte-lane writes, 1-cycle registered reads, zero-fill after reset.
// Accepts one request per cycle with no back-pressure; requests during the clear are dropped and flagged.
module data_sram_responder #(
  parameter int          ADDR_WIDTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  input  logic [3:0]  data_sram_we,
  output logic [31:0] data_sram_rdata,
  output logic        init_done,
  output logic        req_drop,
  output logic        addr_err,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [31:0]           mem [DEPTH];
  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  in_range;
  logic                  is_read;
  logic                  acc_rd;
  logic                  acc_wr;
  logic                  bad_rd;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^data_sram_addr[1:0];

  assign idx       = data_sram_addr[ADDR_WIDTH+1:2];
  assign in_range  = (data_sram_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign init_done = (state == ST_READY);
  assign is_read   = (data_sram_we == 4'h0);

  assign acc_wr = init_done && data_sram_en && in_range && !is_read;
  assign acc_rd = init_done && data_sram_en && in_range && is_read;
  assign bad_rd = init_done && data_sram_en && !in_range && is_read;

  // Storage has no reset; the INIT walk is the only thing that zeroes it.
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (state == ST_INIT) begin
        mem[clr_idx] <= 32'h0;
      end else if (acc_wr) begin
        for (int i = 0; i < 4; i++) begin
          if (data_sram_we[i]) mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= INIT_CLEAR ? ST_INIT : ST_READY;
      clr_idx         <= '0;
      data_sram_rdata <= 32'h0;
      req_drop        <= 1'b0;
      addr_err        <= 1'b0;
      rd_cnt          <= 32'h0;
      wr_cnt          <= 32'h0;
    end else begin
      req_drop <= data_sram_en && !init_done;
      addr_err <= data_sram_en && init_done && !in_range;

      if (state == ST_INIT) begin
        clr_idx <= clr_idx + 1'b1;
        if (&clr_idx) state <= ST_READY;
      end

      if (acc_rd) begin
        data_sram_rdata <= mem[idx];
        rd_cnt          <= rd_cnt + 32'h1;
      end else if (bad_rd) begin
        data_sram_rdata <= 32'h0;
      end

      if (acc_wr) wr_cnt <= wr_cnt + 32'h1;
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder with a 16-word array at base 0.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        data_sram_en;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_rdata;
  logic        init_done;
  logic        req_drop;
  logic        addr_err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_init;
  logic [31:0] exp_mem [16];

  always #5 clk = ~clk;

  data_sram_responder #(
    .ADDR_WIDTH (4),
    .BASE_ADDR  (32'h0000_0000),
    .INIT_CLEAR (1'b1)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_we    (data_sram_we),
    .data_sram_rdata (data_sram_rdata),
    .init_done       (init_done),
    .req_drop        (req_drop),
    .addr_err        (addr_err),
    .rd_cnt          (rd_cnt),
    .wr_cnt          (wr_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request for a single edge; outputs are sampled 1 ns after that edge.
  task automatic cyc(input logic en, input logic [31:0] a, input logic [31:0] w, input logic [3:0] we);
    data_sram_en    = en;
    data_sram_addr  = a;
    data_sram_wdata = w;
    data_sram_we    = we;
    @(posedge clk);
    #1;
    data_sram_en = 1'b0;
    data_sram_we = 4'h0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // Counts sampled cycles with init_done low; bounded so a stuck FSM still ends the run.
  task automatic count_init(output int n);
    n = 0;
    while (!init_done && n < 200) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    resetn          = 1'b0;
    data_sram_en    = 1'b0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    data_sram_we    = 4'h0;
    for (int i = 0; i < 16; i++) exp_mem[i] = 32'h0;

    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_rdata", data_sram_rdata, 32'h0);
    check("rst_init_done", {31'h0, init_done}, 32'h0);
    check("rst_req_drop", {31'h0, req_drop}, 32'h0);
    check("rst_addr_err", {31'h0, addr_err}, 32'h0);
    check("rst_rd_cnt", rd_cnt, 32'h0);
    check("rst_wr_cnt", wr_cnt, 32'h0);

    // 1: clear takes exactly 16 cycles, then memory reads zero
    resetn = 1'b1;
    count_init(n_init);
    check("t1_init_len", n_init, 32'd16);
    check("t1_init_done", {31'h0, init_done}, 32'h1);
    cyc(1'b1, 32'h3C, 32'h0, 4'h0);
    check("t1_rd_3c", data_sram_rdata, 32'h0);

    // 2: full write, single-lane merge, read-after-write
    cyc(1'b1, 32'h8, 32'h1122_3344, 4'hF);
    cyc(1'b1, 32'h8, 32'h0000_AB00, 4'b0010);
    check("t2_rdata_hold_on_wr", data_sram_rdata, 32'h0);
    cyc(1'b1, 32'h8, 32'h0, 4'h0);
    check("t2_rd_merge", data_sram_rdata, 32'h1122_AB44);
    check("t2_wr_cnt", wr_cnt, 32'd2);
    check("t2_rd_cnt", rd_cnt, 32'd2);  // includes the 0x3C read
    exp_mem[2] = 32'h1122_AB44;

    // 3: rdata holds through idle cycles and a write
    cyc(1'b1, 32'h8, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'h0, 32'h0, 4'h0);
      check("t3_idle_hold", data_sram_rdata, 32'h1122_AB44);
    end
    cyc(1'b1, 32'h4, 32'h5566_7788, 4'hF);
    exp_mem[1] = 32'h5566_7788;
    check("t3_wr_hold", data_sram_rdata, 32'h1122_AB44);
    check("t3_rd_cnt", rd_cnt, 32'd3);
    check("t3_wr_cnt", wr_cnt, 32'd3);

    // 4: out-of-range read/write
    cyc(1'b1, 32'h100, 32'h0, 4'h0);
    check("t4_oor_rdata", data_sram_rdata, 32'h0);
    check("t4_addr_err", {31'h0, addr_err}, 32'h1);
    check("t4_oor_rd_cnt", rd_cnt, 32'd3);
    cyc(1'b0, 32'h0, 32'h0, 4'h0);
    check("t4_addr_err_pulse", {31'h0, addr_err}, 32'h0);
    cyc(1'b1, 32'h100, 32'hA5A5_A5A5, 4'hF);
    check("t4_wr_addr_err", {31'h0, addr_err}, 32'h1);
    check("t4_oor_wr_cnt", wr_cnt, 32'd3);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 32'(i * 4), 32'h0, 4'h0);
      check($sformatf("t4_word%0d", i), data_sram_rdata, exp_mem[i]);
      check("t4_no_err", {31'h0, addr_err}, 32'h0);
    end
    check("t4_rd_cnt", rd_cnt, 32'd19);

    // 5: requests during the clear are dropped
    do_reset();
    for (int i = 0; i < 16; i++) exp_mem[i] = 32'h0;
    check("t5_rst_rd_cnt", rd_cnt, 32'h0);
    cyc(1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF);
    check("t5_req_drop", {31'h0, req_drop}, 32'h1);
    check("t5_init_busy", {31'h0, init_done}, 32'h0);
    cyc(1'b0, 32'h0, 32'h0, 4'h0);
    check("t5_req_drop_pulse", {31'h0, req_drop}, 32'h0);
    count_init(n_init);
    check("t5_init_rest", n_init, 32'd14);
    cyc(1'b1, 32'h0, 32'h0, 4'h0);
    check("t5_rd_0", data_sram_rdata, 32'h0);
    check("t5_wr_cnt", wr_cnt, 32'h0);
    check("t5_rd_cnt", rd_cnt, 32'h1);

    // 6: reset in READY reruns the clear and zeroes the counters
    cyc(1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF);
    check("t6_wr_cnt_pre", wr_cnt, 32'h1);
    cyc(1'b1, 32'h4, 32'h0, 4'h0);
    check("t6_rd_pre", data_sram_rdata, 32'hDEAD_BEEF);
    do_reset();
    check("t6_rst_rdata", data_sram_rdata, 32'h0);
    check("t6_rst_rd_cnt", rd_cnt, 32'h0);
    check("t6_rst_wr_cnt", wr_cnt, 32'h0);
    count_init(n_init);
    check("t6_init_len", n_init, 32'd16);
    cyc(1'b1, 32'h4, 32'h0, 4'h0);
    check("t6_rd_4", data_sram_rdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
